// File: rtl/apb_slave_regfile_pkg.sv
// apb_slv_pkg: shared constants for the APB slave register file.
// FSM encoding, response codes and default window base.
package apb_slv_pkg;
  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] SETUP  = 2'b01;
  localparam logic [1:0] ACCESS = 2'b10;

  localparam logic OKAY   = 1'b0;
  localparam logic SLVERR = 1'b1;

  localparam logic [31:0] ADDR_BASE_DEF = 32'h0000_A000;
endpackage

// File: rtl/apb_slave_regfile_if.sv
// apb_slave_regfile_if: APB bus bundle between master and register file.
// Clock and reset stay outside as plain ports.
interface apb_slave_regfile_if;
  logic        PSELx;
  logic        P_en;
  logic        P_WR;
  logic [31:0] Paddr;
  logic [31:0] PWdata;
  logic [31:0] PRdata;
  logic        P_ready;
  logic        P_slverr;

  modport master (
    output PSELx, P_en, P_WR, Paddr, PWdata,
    input  PRdata, P_ready, P_slverr
  );

  modport slave (
    input  PSELx, P_en, P_WR, Paddr, PWdata,
    output PRdata, P_ready, P_slverr
  );
endinterface

// File: rtl/apb_slave_regfile_decode.sv
// apb_slv_decode: window/alignment check and word index extraction.
// Purely combinational; fed with the latched transfer address.
module apb_slv_decode
  import apb_slv_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = ADDR_BASE_DEF,
  parameter int          NUM_REGS  = 8
) (
  input  logic [31:0]                 addr,
  output logic                        err,
  output logic [$clog2(NUM_REGS)-1:0] index
);
  localparam int          IW  = $clog2(NUM_REGS);
  localparam logic [31:0] WIN = 32'(4 * NUM_REGS);

  logic [31:0] offset;

  // offset from base, error flags and register index
  always_comb begin
    offset = addr - ADDR_BASE;
    err    = (addr[1:0] != 2'b00)
           | (addr < ADDR_BASE)
           | (offset >= WIN);
    index  = offset[IW+1:2];
  end
endmodule

// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile: APB register file with programmable wait states.
// APB_SLV_XFER_CNT_EN turns the last register into a transfer counter.
module apb_slave_regfile
  import apb_slv_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = ADDR_BASE_DEF,
  parameter int          NUM_REGS    = 8,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic               Pclk,
  input  logic               Prst,
  apb_slave_regfile_if.slave bus
);
  localparam int            IW   = $clog2(NUM_REGS);
  localparam logic [3:0]    WAIT = 4'(WAIT_CYCLES);
  localparam logic [IW-1:0] LAST = IW'(NUM_REGS - 1);

  logic [1:0]    state, state_d;
  logic [3:0]    cnt;
  logic [31:0]   addr_q, data_q;
  logic          wr_q;
  logic [31:0]   addr_d, data_d;
  logic          wr_d;
  logic          capture, step, complete;
  logic          dec_err, err_eff, commit;
  logic [IW-1:0] idx;
  logic [31:0]   rd_val;
  logic [31:0]   regs [NUM_REGS];
`ifdef APB_SLV_XFER_CNT_EN
  logic [31:0]   xfer_cnt;
`endif

  // With zero waits the response is decided in the setup cycle itself,
  // so decode looks at the value being latched, not the old one.
  apb_slv_decode #(
    .ADDR_BASE (ADDR_BASE),
    .NUM_REGS  (NUM_REGS)
  ) u_dec (
    .addr  (addr_d),
    .err   (dec_err),
    .index (idx)
  );

  // transfer qualifiers and effective latched values
  always_comb begin
    capture  = bus.PSELx & ~bus.P_en
             & ((state == IDLE)
             | ((state == ACCESS) & bus.P_ready));
    step     = bus.PSELx & bus.P_en
             & ((state == SETUP)
             | ((state == ACCESS) & ~bus.P_ready));
    complete = (capture & (WAIT == 4'd0))
             | (step & (cnt == 4'd1));
    addr_d   = capture ? bus.Paddr  : addr_q;
    data_d   = capture ? bus.PWdata : data_q;
    wr_d     = capture ? bus.P_WR   : wr_q;
`ifdef APB_SLV_XFER_CNT_EN
    err_eff  = dec_err | (wr_d & (idx == LAST));
    rd_val   = (idx == LAST) ? xfer_cnt : regs[idx];
`else
    err_eff  = dec_err;
    rd_val   = regs[idx];
`endif
    commit   = complete & wr_d & ~err_eff;
  end

  // next-state decode
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (capture)
          state_d = (WAIT == 4'd0) ? ACCESS : SETUP;
      end
      SETUP: begin
        if (!bus.PSELx)
          state_d = IDLE;
        else if (step)
          state_d = ACCESS;
      end
      ACCESS: begin
        if (bus.P_ready)
          state_d = !capture ? IDLE
                  : (WAIT == 4'd0) ? ACCESS : SETUP;
        else if (!bus.PSELx)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state, wait counter and transfer latch
  always_ff @(posedge Pclk or negedge Prst) begin
    if (!Prst) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      addr_q <= 32'h0;
      data_q <= 32'h0;
      wr_q   <= 1'b0;
    end else begin
      state <= state_d;
      if (capture) begin
        addr_q <= bus.Paddr;
        data_q <= bus.PWdata;
        wr_q   <= bus.P_WR;
        cnt    <= WAIT;
      end else if (step && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  // registered response, zero outside the completion cycle
  always_ff @(posedge Pclk or negedge Prst) begin
    if (!Prst) begin
      bus.P_ready  <= 1'b0;
      bus.P_slverr <= OKAY;
      bus.PRdata   <= 32'h0;
    end else begin
      bus.P_ready  <= complete;
      bus.P_slverr <= (complete & err_eff) ? SLVERR : OKAY;
      bus.PRdata   <= (complete & ~wr_d & ~err_eff)
                    ? rd_val : 32'h0;
    end
  end

  // register array write commit
  always_ff @(posedge Pclk or negedge Prst) begin
    if (!Prst) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= 32'h0;
    end else if (commit) begin
      regs[idx] <= data_d;
    end
  end

`ifdef APB_SLV_XFER_CNT_EN
  // count of completed good transfers
  always_ff @(posedge Pclk or negedge Prst) begin
    if (!Prst)
      xfer_cnt <= 32'h0;
    else if (complete && !err_eff)
      xfer_cnt <= xfer_cnt + 32'd1;
  end
`endif
endmodule

// File: tb/tb_apb_slave_regfile.sv
// tb_apb_slave_regfile: directed bench for the APB register file.
// Uses a 2-wait and a 0-wait instance on a shared bus drive.
module tb_apb_slave_regfile;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        psel = 1'b0;
  logic        en = 1'b0;
  logic        wr = 1'b0;
  logic        sel0 = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  int          n_tests = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  apb_slave_regfile_if if2 ();
  apb_slave_regfile_if if0 ();

  assign if2.PSELx  = psel & ~sel0;
  assign if2.P_en   = en;
  assign if2.P_WR   = wr;
  assign if2.Paddr  = addr;
  assign if2.PWdata = wdata;
  assign if0.PSELx  = psel & sel0;
  assign if0.P_en   = en;
  assign if0.P_WR   = wr;
  assign if0.Paddr  = addr;
  assign if0.PWdata = wdata;

  logic [31:0] rdata_o;
  logic        ready_o, slverr_o;
  assign rdata_o  = sel0 ? if0.PRdata   : if2.PRdata;
  assign ready_o  = sel0 ? if0.P_ready  : if2.P_ready;
  assign slverr_o = sel0 ? if0.P_slverr : if2.P_slverr;

  apb_slave_regfile #(.WAIT_CYCLES(2)) u_dut2 (
    .Pclk (clk),
    .Prst (rst_n),
    .bus  (if2)
  );

  apb_slave_regfile #(.WAIT_CYCLES(0)) u_dut0 (
    .Pclk (clk),
    .Prst (rst_n),
    .bus  (if0)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic xfer(input bit w,
                      input logic [31:0] a,
                      input logic [31:0] d,
                      input int abort_at,
                      input bit hold,
                      output logic [31:0] rd,
                      output logic se,
                      output int lat);
    rd = 32'h0;
    se = 1'b0;
    lat = 0;
    @(posedge clk); #1;
    psel = 1'b1; en = 1'b0; wr = w;
    addr = a; wdata = d;
    @(posedge clk); #1;
    en = 1'b1; addr = ~a; wdata = ~d;
    for (int n = 1; n <= 12; n++) begin
      if (n == abort_at) psel = 1'b0;
      @(negedge clk);
      if (ready_o) begin
        lat = n; rd = rdata_o; se = slverr_o;
        break;
      end
      @(posedge clk); #1;
    end
    if (!hold) begin
      @(posedge clk); #1;
      psel = 1'b0; en = 1'b0;
    end
  endtask

  task automatic rd_chk(input string tag,
                        input logic [31:0] a,
                        input logic [31:0] exp);
    logic [31:0] r;
    logic        s;
    int          l;
    xfer(1'b0, a, 32'h0, 0, 1'b0, r, s, l);
    check({tag, " done"}, 32'(l != 0), 32'd1);
    check(tag, r, exp);
    check({tag, " err"}, 32'(s), 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        se;
    int          lat;
    logic        seen;

    repeat (2) @(posedge clk);
    #1;
    check("rst ready", 32'(if2.P_ready), 32'd0);
    check("rst rdata", if2.PRdata, 32'h0);
    check("rst slverr", 32'(if2.P_slverr), 32'd0);
    check("rst ready0", 32'(if0.P_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    xfer(1'b0, 32'hA004, 32'h0, 0, 1'b0, rd, se, lat);
    check("idle rd lat", lat, 32'd3);
    check("idle rd data", rd, 32'h0);
    check("idle rd err", 32'(se), 32'd0);

    xfer(1'b1, 32'hA008, 32'hDEAD_BEEF, 0, 1'b0, rd, se, lat);
    check("wr A008 lat", lat, 32'd3);
    check("wr A008 err", 32'(se), 32'd0);
    rd_chk("rb A008", 32'hA008, 32'hDEAD_BEEF);
    rd_chk("rb A000", 32'hA000, 32'h0);
    rd_chk("rb A00C", 32'hA00C, 32'h0);

    xfer(1'b1, 32'hA002, 32'h55, 0, 1'b0, rd, se, lat);
    check("unalign lat", lat, 32'd3);
    check("unalign err", 32'(se), 32'd1);
    rd_chk("after unalign", 32'hA000, 32'h0);

    xfer(1'b0, 32'hA020, 32'h0, 0, 1'b0, rd, se, lat);
    check("oow lat", lat, 32'd3);
    check("oow err", 32'(se), 32'd1);
    check("oow data", rd, 32'h0);
    rd_chk("after oow", 32'hA000, 32'h0);

    xfer(1'b1, 32'h9FFC, 32'h66, 0, 1'b0, rd, se, lat);
    check("below lat", lat, 32'd3);
    check("below err", 32'(se), 32'd1);
    rd_chk("after below", 32'hA000, 32'h0);
`ifndef APB_SLV_XFER_CNT_EN
    rd_chk("below A01C", 32'hA01C, 32'h0);
`endif

    @(posedge clk); #1;
    psel = 1'b1; en = 1'b1; wr = 1'b0; addr = 32'hA008;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen |= ready_o;
    end
    @(posedge clk); #1;
    psel = 1'b0; en = 1'b0;
    check("no setup", 32'(seen), 32'd0);

    sel0 = 1'b1;
    xfer(1'b1, 32'hA000, 32'd1, 0, 1'b1, rd, se, lat);
    check("zw wr1 lat", lat, 32'd1);
    check("zw wr1 err", 32'(se), 32'd0);
    xfer(1'b1, 32'hA004, 32'd2, 0, 1'b0, rd, se, lat);
    check("zw wr2 lat", lat, 32'd1);
    check("zw wr2 err", 32'(se), 32'd0);
    xfer(1'b0, 32'hA000, 32'h0, 0, 1'b0, rd, se, lat);
    check("zw rd lat", lat, 32'd1);
    check("zw rd A000", rd, 32'd1);
    rd_chk("zw rd A004", 32'hA004, 32'd2);
    sel0 = 1'b0;

    xfer(1'b1, 32'hA00C, 32'h1234, 2, 1'b0, rd, se, lat);
    check("abort no ready", lat, 32'd0);
    rd_chk("abort A00C", 32'hA00C, 32'h0);

    @(posedge clk); #1;
    psel = 1'b1; en = 1'b0; wr = 1'b0; addr = 32'hA008;
    @(posedge clk); #1;
    en = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    check("pre rst ready", 32'(ready_o), 32'd1);
    check("pre rst rdata", rdata_o, 32'hDEAD_BEEF);
    rst_n = 1'b0;
    #1;
    check("rst1 ready", 32'(ready_o), 32'd0);
    check("rst1 rdata", rdata_o, 32'h0);
    psel = 1'b0; en = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    @(posedge clk); #1;
    psel = 1'b1; en = 1'b0; wr = 1'b1;
    addr = 32'hA010; wdata = 32'h55;
    @(posedge clk); #1;
    en = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst2 ready", 32'(ready_o), 32'd0);
    check("rst2 slverr", 32'(slverr_o), 32'd0);
    psel = 1'b0; en = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    rd_chk("post rst A008", 32'hA008, 32'h0);
    rd_chk("post rst A010", 32'hA010, 32'h0);
    rd_chk("post rst A004", 32'hA004, 32'h0);
    sel0 = 1'b1;
    rd_chk("post rst zw A000", 32'hA000, 32'h0);
    sel0 = 1'b0;

`ifdef APB_SLV_XFER_CNT_EN
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    xfer(1'b1, 32'hA000, 32'd7, 0, 1'b0, rd, se, lat);
    check("cnt wr1 err", 32'(se), 32'd0);
    xfer(1'b1, 32'hA004, 32'd8, 0, 1'b0, rd, se, lat);
    check("cnt wr2 err", 32'(se), 32'd0);
    rd_chk("cnt rd A000", 32'hA000, 32'd7);
    rd_chk("cnt value", 32'hA01C, 32'd3);
    xfer(1'b1, 32'hA01C, 32'h0, 0, 1'b0, rd, se, lat);
    check("cnt wr lat", lat, 32'd3);
    check("cnt wr err", 32'(se), 32'd1);
    rd_chk("cnt after wr", 32'hA01C, 32'd4);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
